// File: rtl/left_shift_seq_pkg.sv
// Shared constants for the multi-cycle left shifter: state encoding, amount width
// and the binary stage weights applied MSB-first.
package left_shift_seq_pkg;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned SHAMT_W    = 5;
    localparam int unsigned NUM_STAGES = SHAMT_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int unsigned STAGE_WEIGHT [NUM_STAGES] = '{16, 8, 4, 2, 1};

    // Weight of stage k when n stages are walked from the largest weight down.
    function automatic int unsigned stage_weight(input int unsigned k, input int unsigned n);
        return 32'd1 << (n - 32'd1 - k);
    endfunction

endpackage

// File: rtl/left_shift_stage.sv
// One fixed-distance, zero-filling left shift stage.
module left_shift_stage #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SHIFT_BY = 1
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_c
);

    assign data_c = data_i << SHIFT_BY;

endmodule

// File: rtl/left_shift_seq.sv
// Multi-cycle logical left shifter: one binary-weighted stage per cycle
// (largest weight first), start/done handshake, fixed latency regardless of amount.
module left_shift_seq #(
    parameter int unsigned WIDTH   = left_shift_seq_pkg::WIDTH,
    parameter int unsigned SHAMT_W = left_shift_seq_pkg::SHAMT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   data_out,
    output logic               busy,
    output logic               done
);
    import left_shift_seq_pkg::*;

    localparam int unsigned    CNT_W    = $clog2(SHAMT_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SHAMT_W - 1);

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               accept_c;
    logic [WIDTH-1:0]   stage_sel_c;
    logic [WIDTH-1:0]   stage_out [SHAMT_W];

    // Stage k shifts by 2**(SHAMT_W-1-k); the counter picks the active one.
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        left_shift_stage #(
            .WIDTH    (WIDTH),
            .SHIFT_BY (stage_weight(k, SHAMT_W))
        ) u_stage (
            .data_i (data_q),
            .data_c (stage_out[k])
        );
    end

    assign stage_sel_c = stage_out[cnt_q];
    assign accept_c    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == LAST_CNT) state_d = ST_DONE;
            ST_DONE:  state_d = start ? ST_SHIFT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // shamt_q is consumed MSB-first by shifting it left once per stage.
    always_comb begin
        data_d  = data_q;
        shamt_d = shamt_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        if (accept_c) begin
            data_d  = data_in;
            shamt_d = shamt;
            cnt_d   = '0;
            busy_d  = 1'b1;
        end else if (state_q == ST_SHIFT) begin
            if (shamt_q[SHAMT_W-1]) begin
                data_d = stage_sel_c;
            end
            shamt_d = shamt_q << 1;
            cnt_d   = cnt_q + CNT_W'(1);
            busy_d  = (cnt_q != LAST_CNT);
            done_d  = (cnt_q == LAST_CNT);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q  <= '0;
            shamt_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            shamt_q <= shamt_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign data_out = data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_left_shift_seq.sv
// Scoreboard bench for left_shift_seq: driver queues expected results, a negedge
// monitor checks result, latency, busy/done and held output against them.
module tb_left_shift_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic [31:0] data_out;
    logic        busy;
    logic        done;

    left_shift_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .data_in  (data_in),
        .shamt    (shamt),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    int edge_n = 0;
    always @(posedge clock) edge_n <= edge_n + 1;

    typedef struct {
        logic [31:0] res;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    int          last_acc = -100;
    logic [31:0] hold_exp = '0;
    bit          mon_en   = 1'b0;
    int          n_cmp    = 0;
    int          n_err    = 0;

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s);
        logic [63:0] p;
        p = {32'd0, d} * (64'd1 << s);
        return p[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h (edge %0d)", name, act, req, edge_n);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present start on the first edge at which the block accepts (IDLE or DONE).
    task automatic issue(input logic [31:0] d, input logic [4:0] s);
        exp_t e;
        while (edge_n + 1 < last_acc + 6) tick();
        start   = 1'b1;
        data_in = d;
        shamt   = s;
        e.res   = ref_shift(d, s);
        e.acc   = edge_n + 1;
        exp_q.push_back(e);
        last_acc = e.acc;
        tick();
        start   = 1'b0;
        data_in = $urandom;
        shamt   = 5'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
        tick();
    endtask

    // Monitor: outputs after edge e, compared against the oldest accepted op.
    always @(negedge clock) begin
        int e;
        int a;
        if (mon_en) begin
            e = edge_n;
            if (exp_q.size() != 0 && exp_q[0].acc <= e) begin
                a = exp_q[0].acc;
                if (done) begin
                    check("done latency", 32'(e - a), 32'd5);
                    check("result", data_out, exp_q[0].res);
                    check("busy with done", 32'(busy), 32'd0);
                    hold_exp = exp_q[0].res;
                    void'(exp_q.pop_front());
                end else if (e >= a + 5) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL done missing: actual=0 required=1 (edge %0d)", e);
                    hold_exp = exp_q[0].res;
                    void'(exp_q.pop_front());
                end else begin
                    check("busy during shift", 32'(busy), 32'd1);
                end
            end else begin
                check("idle done", 32'(done), 32'd0);
                check("idle busy", 32'(busy), 32'd0);
                check("held data_out", data_out, hold_exp);
            end
        end
    end

    initial begin
        logic [31:0] d;
        logic [4:0]  s;
        int          r;

        reset   = 1'b1;
        start   = 1'b0;
        data_in = '0;
        shamt   = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("reset data_out", data_out, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        mon_en = 1'b1;

        issue(32'h0000_0001, 5'd31);
        drain();
        issue(32'hFFFF_FFFF, 5'd8);
        drain();
        issue(32'h1234_5678, 5'd0);
        drain();

        // Start pulsed mid-shift must be ignored.
        issue(32'h0000_000F, 5'd4);
        tick();
        start   = 1'b1;
        data_in = 32'hAAAA_AAAA;
        shamt   = 5'd1;
        tick();
        start   = 1'b0;
        drain();

        // Reset during an operation aborts it with no done pulse.
        issue(32'h0000_0003, 5'd2);
        tick();
        tick();
        reset = 1'b1;
        tick();
        exp_q.delete();
        last_acc = -100;
        hold_exp = '0;
        reset    = 1'b0;
        check("abort data_out", data_out, 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        repeat (3) tick();
        issue(32'h0000_00FF, 5'd5);
        drain();

        // Back-to-back: second start lands in the DONE cycle.
        issue(32'h0000_0001, 5'd1);
        issue(32'h0000_0001, 5'd16);
        drain();

        repeat (40) begin
            d = $urandom;
            r = $urandom_range(0, 9);
            s = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : 5'($urandom);
            repeat ($urandom_range(0, 2)) tick();
            issue(d, s);
        end
        drain();

        check("queue drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
